// File: rtl/obi_rr_share.sv
// obi_rr_share: round-robin sharing of one OBI subordinate among NumSbrPorts managers.
// Optional burst grants are enabled by defining OBI_RR_SHARE_BURST_EN.

package obi_pkg;
    typedef struct packed {
        logic        UseRReady;
        int unsigned AddrWidth;
        int unsigned DataWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b0, AddrWidth: 32, DataWidth: 32};

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_a_chan_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
        logic        rready;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module obi_rr_share #(
    parameter obi_pkg::obi_cfg_t ObiCfg      = obi_pkg::ObiDefaultConfig,
    parameter type               obi_req_t   = obi_pkg::obi_req_t,
    parameter type               obi_rsp_t   = obi_pkg::obi_rsp_t,
    parameter int unsigned       NumSbrPorts = 2,
    parameter int unsigned       MaxTrans    = 4,
    parameter int unsigned       BurstLen    = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t sbr_ports_req_i [NumSbrPorts],
    output obi_rsp_t sbr_ports_rsp_o [NumSbrPorts],
    output obi_req_t mgr_port_req_o,
    input  obi_rsp_t mgr_port_rsp_i
);

    localparam int unsigned     IdxW    = $clog2(NumSbrPorts);
    localparam int unsigned     CntW    = $clog2(MaxTrans + 1);
    localparam int unsigned     PtrW    = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSbrPorts - 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxTrans - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(MaxTrans);

    logic [IdxW-1:0] r_last;
    logic [IdxW-1:0] r_sel;
    logic            r_lock;
    logic [IdxW-1:0] r_fifo [MaxTrans];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;

    logic [NumSbrPorts-1:0] w_req_vec;
    logic [IdxW-1:0]        w_next_last;
    logic [IdxW-1:0]        w_start;
    logic [IdxW-1:0]        w_pick;
    logic                   w_found;
    logic [IdxW-1:0]        w_sel;
    logic                   w_sel_req;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_mgr_req;
    logic                   w_hs;
    logic [IdxW-1:0]        w_head;
    logic                   w_head_rready;
    logic                   w_rsp_ok;
    logic                   w_pop;
    logic                   w_burst_hold;

    // First requester at or after start, wrapping modulo NumSbrPorts; MSB flags a hit.
    function automatic logic [IdxW:0] rr_pick(input logic [NumSbrPorts-1:0] reqs,
                                              input logic [IdxW-1:0]        start);
        logic [IdxW:0]   res;
        logic [IdxW-1:0] cand;
        res = '0;
        for (int unsigned k = 0; k < NumSbrPorts; k++) begin
            cand = IdxW'((32'(start) + k) % NumSbrPorts);
            if (!res[IdxW] && reqs[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NumSbrPorts; i++) begin
            w_req_vec[i] = sbr_ports_req_i[i].req;
        end
    end

    assign w_full      = (r_count == FullCnt);
    assign w_empty     = (r_count == '0);
    assign w_next_last = (r_last == LastIdx) ? '0 : r_last + 1'b1;
    assign w_start     = w_burst_hold ? r_last : w_next_last;

    assign {w_found, w_pick} = rr_pick(w_req_vec, w_start);

    // A pending ungranted request pins the selection so the OBI request stays stable.
    assign w_sel     = r_lock ? r_sel : w_pick;
    assign w_sel_req = r_lock ? w_req_vec[r_sel] : w_found;
    assign w_mgr_req = w_sel_req & ~w_full;
    assign w_hs      = w_mgr_req & mgr_port_rsp_i.gnt;

    assign w_head        = r_fifo[r_rptr];
    assign w_head_rready = ObiCfg.UseRReady ? sbr_ports_req_i[w_head].rready : 1'b1;
    assign w_rsp_ok      = mgr_port_rsp_i.rvalid & ~w_empty;
    assign w_pop         = w_rsp_ok & w_head_rready;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        mgr_port_req_o        = sbr_ports_req_i[w_sel];
        mgr_port_req_o.req    = w_mgr_req;
        mgr_port_req_o.rready = w_head_rready;
    end

    always_comb begin
        for (int unsigned i = 0; i < NumSbrPorts; i++) begin
            sbr_ports_rsp_o[i]        = '0;
            sbr_ports_rsp_o[i].r      = mgr_port_rsp_i.r;
            sbr_ports_rsp_o[i].gnt    = w_hs && (w_sel == IdxW'(i));
            sbr_ports_rsp_o[i].rvalid = w_rsp_ok && (w_head == IdxW'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last <= LastIdx;
            r_sel  <= '0;
            r_lock <= 1'b0;
        end else begin
            r_lock <= w_mgr_req & ~mgr_port_rsp_i.gnt;
            if (w_mgr_req) r_sel <= w_sel;
            if (w_hs) r_last <= w_sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_hs) r_wptr <= (r_wptr == LastPtr) ? '0 : r_wptr + 1'b1;
            if (w_pop) r_rptr <= (r_rptr == LastPtr) ? '0 : r_rptr + 1'b1;
            case ({w_hs, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: ID storage has no reset; r_count alone decides which entries are live.
    always_ff @(posedge clk_i) begin
        if (w_hs) r_fifo[r_wptr] <= w_sel;
    end

`ifdef OBI_RR_SHARE_BURST_EN
    localparam int unsigned       BurstW   = $clog2(BurstLen + 1);
    localparam logic [BurstW-1:0] BurstMax = BurstW'(BurstLen);

    logic [BurstW-1:0] r_burst;

    // A zero count means last_q has no live burst, so reset still lets port 0 win first.
    assign w_burst_hold = w_req_vec[r_last] && (r_burst != '0) && (r_burst < BurstMax);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_burst <= '0;
        end else if (w_hs) begin
            if (w_sel != r_last) r_burst <= BurstW'(1);
            else if (r_burst != BurstMax) r_burst <= r_burst + 1'b1;
        end else if (!w_req_vec[r_last]) begin
            r_burst <= '0;
        end
    end
`else
    assign w_burst_hold = 1'b0;
`endif

    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mgr_port_rsp_i.rvalid && w_empty));

endmodule

// File: tb/tb_obi_rr_share.sv
// Directed self-checking bench for obi_rr_share: 3 requesters, 2-deep ID FIFO, BurstLen 2.

module tb_obi_rr_share;

    localparam int unsigned NPorts = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    obi_pkg::obi_req_t sbr_req [NPorts];
    obi_pkg::obi_rsp_t sbr_rsp [NPorts];
    obi_pkg::obi_req_t mgr_req;
    obi_pkg::obi_rsp_t mgr_rsp;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef OBI_RR_SHARE_BURST_EN
    int fair_exp [6] = '{0, 0, 1, 1, 2, 2};
`else
    int fair_exp [6] = '{0, 1, 2, 0, 1, 2};
`endif

    always #5 clk = ~clk;

    obi_rr_share #(
        .ObiCfg     (obi_pkg::ObiDefaultConfig),
        .obi_req_t  (obi_pkg::obi_req_t),
        .obi_rsp_t  (obi_pkg::obi_rsp_t),
        .NumSbrPorts(NPorts),
        .MaxTrans   (2),
        .BurstLen   (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sbr_ports_req_i(sbr_req),
        .sbr_ports_rsp_o(sbr_rsp),
        .mgr_port_req_o (mgr_req),
        .mgr_port_rsp_i (mgr_rsp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gnts();
        return {29'b0, sbr_rsp[2].gnt, sbr_rsp[1].gnt, sbr_rsp[0].gnt};
    endfunction

    function automatic logic [31:0] rvalids();
        return {29'b0, sbr_rsp[2].rvalid, sbr_rsp[1].rvalid, sbr_rsp[0].rvalid};
    endfunction

    task automatic idle();
        for (int i = 0; i < NPorts; i++) sbr_req[i] = '0;
        mgr_rsp = '0;
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        #1;
        rst_n = 1'b0;
        tick();
        tick();
        settle();
        check("rst_mgr_req", 32'(mgr_req.req), 0);
        check("rst_gnt", gnts(), 0);
        check("rst_rvalid", rvalids(), 0);
        check("rst_count", 32'(dut.r_count), 0);
        tick();
        rst_n = 1'b1;

        // Single requester: same-cycle grant, response two cycles later.
        sbr_req[0].req    = 1'b1;
        sbr_req[0].a.addr = 32'h10;
        mgr_rsp.gnt       = 1'b1;
        settle();
        check("t1_mgr_req", 32'(mgr_req.req), 1);
        check("t1_addr", mgr_req.a.addr, 32'h10);
        check("t1_gnt", gnts(), 32'h1);
        tick();
        idle();
        settle();
        check("t1_wait_rvalid", rvalids(), 0);
        check("t1_wait_gnt", gnts(), 0);
        tick();
        mgr_rsp.rvalid  = 1'b1;
        mgr_rsp.r.rdata = 32'h55;
        settle();
        check("t1_rvalid", rvalids(), 32'h1);
        check("t1_rdata", sbr_rsp[0].r.rdata, 32'h55);
        tick();
        idle();

        // Fairness: every port requests, subordinate grants and answers next cycle.
        do_reset();
        for (int i = 0; i < NPorts; i++) begin
            sbr_req[i].req    = 1'b1;
            sbr_req[i].a.addr = 32'h100 + i;
        end
        for (int t = 0; t < 6; t++) begin
            mgr_rsp         = '0;
            mgr_rsp.gnt     = 1'b1;
            mgr_rsp.rvalid  = (t > 0);
            mgr_rsp.r.rdata = 32'h200 + t;
            settle();
            check($sformatf("t2_grant%0d", t), gnts(), 32'(1) << fair_exp[t]);
            check($sformatf("t2_addr%0d", t), mgr_req.a.addr, 32'h100 + fair_exp[t]);
            if (t > 0) check($sformatf("t2_rvalid%0d", t), rvalids(), 32'(1) << fair_exp[t-1]);
            tick();
        end
        idle();
        mgr_rsp.rvalid = 1'b1;
        settle();
        check("t2_drain", rvalids(), 32'(1) << fair_exp[5]);
        tick();
        idle();

        // Lock: port 1 held while port 0 joins during the wait.
        do_reset();
        sbr_req[1].req    = 1'b1;
        sbr_req[1].a.addr = 32'h111;
        sbr_req[2].req    = 1'b1;
        sbr_req[2].a.addr = 32'h222;
        for (int t = 0; t < 3; t++) begin
            if (t > 0) begin
                sbr_req[0].req    = 1'b1;
                sbr_req[0].a.addr = 32'hAA;
            end
            settle();
            check($sformatf("t3_req%0d", t), 32'(mgr_req.req), 1);
            check($sformatf("t3_addr%0d", t), mgr_req.a.addr, 32'h111);
            check($sformatf("t3_nogrant%0d", t), gnts(), 0);
            tick();
        end
        mgr_rsp.gnt = 1'b1;
        settle();
        check("t3_grant_p1", gnts(), 32'h2);
        tick();
        sbr_req[1].req = 1'b0;
        settle();
        check("t3_grant_p2", gnts(), 32'h4);
        check("t3_addr_p2", mgr_req.a.addr, 32'h222);
        tick();
        idle();
        mgr_rsp.rvalid = 1'b1;
        settle();
        check("t3_rsp_p1", rvalids(), 32'h2);
        tick();
        settle();
        check("t3_rsp_p2", rvalids(), 32'h4);
        tick();
        idle();

        // FIFO full: a pop in the same cycle does not unblock the push.
        do_reset();
        sbr_req[0].req    = 1'b1;
        sbr_req[0].a.addr = 32'h40;
        mgr_rsp.gnt       = 1'b1;
        settle();
        check("t4_grant_a", gnts(), 32'h1);
        tick();
        settle();
        check("t4_grant_b", gnts(), 32'h1);
        tick();
        settle();
        check("t4_full_req", 32'(mgr_req.req), 0);
        check("t4_full_gnt", gnts(), 0);
        check("t4_full_count", 32'(dut.r_count), 2);
        tick();
        mgr_rsp.rvalid = 1'b1;
        settle();
        check("t4_pop_req", 32'(mgr_req.req), 0);
        check("t4_pop_gnt", gnts(), 0);
        check("t4_pop_rvalid", rvalids(), 32'h1);
        tick();
        mgr_rsp.rvalid = 1'b0;
        settle();
        check("t4_after_req", 32'(mgr_req.req), 1);
        check("t4_after_gnt", gnts(), 32'h1);
        tick();
        sbr_req[0].req = 1'b0;
        mgr_rsp.gnt    = 1'b0;
        mgr_rsp.rvalid = 1'b1;
        tick();
        tick();
        idle();
        settle();
        check("t4_drained", 32'(dut.r_count), 0);
        tick();

        // Response routing: grants 2, 0, 2 with in-order data A, B, C.
        do_reset();
        sbr_req[2].req = 1'b1;
        mgr_rsp.gnt    = 1'b1;
        settle();
        check("t5_grant_2a", gnts(), 32'h4);
        tick();
        sbr_req[2].req = 1'b0;
        sbr_req[0].req = 1'b1;
        settle();
        check("t5_grant_0", gnts(), 32'h1);
        tick();
        sbr_req[0].req  = 1'b0;
        sbr_req[2].req  = 1'b1;
        mgr_rsp.rvalid  = 1'b1;
        mgr_rsp.r.rdata = 32'hA;
        settle();
        check("t5_full_gnt", gnts(), 0);
        check("t5_rv_a", rvalids(), 32'h4);
        check("t5_data_a", sbr_rsp[2].r.rdata, 32'hA);
        tick();
        mgr_rsp.r.rdata = 32'hB;
        settle();
        check("t5_grant_2b", gnts(), 32'h4);
        check("t5_rv_b", rvalids(), 32'h1);
        check("t5_data_b", sbr_rsp[0].r.rdata, 32'hB);
        tick();
        sbr_req[2].req  = 1'b0;
        mgr_rsp.gnt     = 1'b0;
        mgr_rsp.r.rdata = 32'hC;
        settle();
        check("t5_rv_c", rvalids(), 32'h4);
        check("t5_data_c", sbr_rsp[2].r.rdata, 32'hC);
        tick();
        idle();

        // Reset mid-flight: outstanding IDs vanish and port 0 wins again.
        do_reset();
        sbr_req[1].req = 1'b1;
        mgr_rsp.gnt    = 1'b1;
        settle();
        check("t6_grant_1", gnts(), 32'h2);
        tick();
        sbr_req[1].req = 1'b0;
        sbr_req[0].req = 1'b1;
        settle();
        check("t6_grant_0", gnts(), 32'h1);
        tick();
        idle();
        rst_n = 1'b0;
        settle();
        check("t6_rst_count", 32'(dut.r_count), 0);
        check("t6_rst_req", 32'(mgr_req.req), 0);
        check("t6_rst_gnt", gnts(), 0);
        check("t6_rst_rvalid", rvalids(), 0);
        tick();
        rst_n          = 1'b1;
        sbr_req[0].req = 1'b1;
        sbr_req[1].req = 1'b1;
        mgr_rsp.gnt    = 1'b1;
        settle();
        check("t6_first_grant", gnts(), 32'h1);
        tick();
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/obi_rr_share.md
# obi_rr_share

Round-robin OBI arbiter that shares one OBI subordinate among `NumSbrPorts` OBI managers. Each request is granted to one requester. The requester index is recorded in an in-order ID FIFO, and the response is routed back to that requester. It sits in front of single-ported peripherals or memory banks, typically with an `obi_cut` on its manager side to break timing.

## Interface
- `ObiCfg`, `obi_pkg::ObiDefaultConfig`: OBI configuration shared by all ports.
- `obi_req_t`, `logic`: request struct (`req`, `a`, `rready`).
- `obi_rsp_t`, `logic`: response struct (`gnt`, `rvalid`, `r`).
- `NumSbrPorts`, 2: number of requesters, range 2..16.
- `MaxTrans`, 4: maximum outstanding transactions and ID FIFO depth, range 1..16.
- `BurstLen`, 4: maximum consecutive grants to one requester (used only with the macro).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `sbr_ports_req_i`  in  `NumSbrPorts` x `obi_req_t`  requester requests.
- `sbr_ports_rsp_o`  out  `NumSbrPorts` x `obi_rsp_t`  requester responses.
- `mgr_port_req_o`  out  `obi_req_t`  request to the shared subordinate.
- `mgr_port_rsp_i`  in  `obi_rsp_t`  response from the shared subordinate.

## Operation
- State registers:
  - `last_q`: last granted index, `$clog2(NumSbrPorts)` bits.
  - `lock_q` and `sel_q`: locked selection.
  - ID FIFO: `MaxTrans` entries, each `$clog2(NumSbrPorts)` bits, with read/write pointers and a `count` of `$clog2(MaxTrans+1)` bits.
- Selection when unlocked:
  - Pick the first requester with `req` set, searching from `last_q+1` upward, modulo `NumSbrPorts`.
  - Otherwise the selection is don't-care and `mgr_port_req_o.req` is 0.
- Request forwarding:
  - `mgr_port_req_o.req = sel.req & ~fifo_full`.
  - `mgr_port_req_o.a = sel.a`.
  - Every other requester sees `gnt` = 0.
- Lock:
  - When `mgr_port_req_o.req` is 1 and `gnt` is 0, set `lock_q` and hold `sel_q` until a handshake.
  - While locked, selection equals `sel_q`, so the OBI request stays stable.
  - `lock_q` clears on the handshake.
- Handshake (`req & gnt`):
  - Route `gnt` to the selected requester only.
  - Push the selected index into the FIFO.
  - Set `last_q` to the selected index.
- Full FIFO (`count == MaxTrans`):
  - No `req` is forwarded and no grant is given.
  - A pop in the same cycle does NOT unblock the push; the block is deterministically stalled for that cycle.
- Response:
  - Head index `h` receives `rvalid = mgr_port_rsp_i.rvalid` and `r = mgr_port_rsp_i.r`.
  - Every other requester sees `rvalid` = 0 and `r` = don't-care.
- `rready`:
  - With `ObiCfg.UseRReady`, `mgr_port_req_o.rready = sbr_ports_req_i[h].rready`, and the pop condition is `rvalid & rready`.
  - Otherwise the pop condition is `rvalid`.
- Push and pop in the same cycle leave `count` unchanged; both pointers advance and wrap at `MaxTrans`.
- `rvalid` while the FIFO is empty is a protocol error. It is dropped, `count` does not underflow, and a simulation assertion fires.

## Timing
- Zero-cycle latency: requester `req` reaches `mgr_port_req_o.req` combinationally, and subordinate `gnt` reaches requester `gnt` combinationally.
- Response routing is combinational from the FIFO head; responses add no latency.
- Reset values:
  - `last_q` = `NumSbrPorts-1`, so port 0 wins first.
  - `lock_q` = 0, `count` = 0, pointers = 0.
  - All `gnt` and `rvalid` outputs are 0 and `mgr_port_req_o.req` is 0.
- Reset asserted mid-transaction discards all outstanding IDs. The subordinate must be reset together with this block.
- Throughput is 1 grant per cycle when the subordinate grants every cycle and `MaxTrans` covers its response latency.

## Configuration
- Macro `OBI_RR_SHARE_BURST_EN`.
- Defined:
  - A burst counter (`$clog2(BurstLen+1)` bits, reset 0) counts consecutive grants to `last_q`.
  - While that requester keeps `req` high and the count is below `BurstLen`, the search starts at `last_q` instead of `last_q+1`.
  - The counter resets to 1 when a grant goes to a different index, or to 0 when `last_q` drops `req`.
- Undefined: strict round-robin, and the counter does not exist.

## Test plan
- **Reset, single requester:** reset; port 0 requests addr `0x10`, subordinate grants immediately and sends `rvalid` 2 cycles later.
  - Port 0 gets `gnt` in the same cycle and `rvalid` 2 cycles later.
  - Port 1 never sees `gnt` or `rvalid`.
- **Fairness:** `NumSbrPorts`=3, all ports request continuously, subordinate always grants.
  - Grant order is 0,1,2,0,1,2 (macro undefined).
  - With the macro and `BurstLen`=2: 0,0,1,1,2,2.
- **Lock:** ports 1 and 2 request, subordinate holds `gnt`=0 for 3 cycles.
  - `mgr_port_req_o.a` stays port 1's payload every cycle.
  - After `gnt`, port 1 is granted; the next grant goes to port 2.
- **FIFO full:** `MaxTrans`=2, subordinate grants but withholds `rvalid`.
  - Third request sees `mgr_port_req_o.req`=0 while count is 2.
  - In the cycle the first `rvalid` pops, there is still no grant; the grant comes the following cycle.
- **Response routing:** grants to ports 2, 0, 2; responses return in order with `r.rdata` `0xA`, `0xB`, `0xC`.
  - Port 2 receives `0xA` and `0xC`; port 0 receives `0xB`.
- **Reset mid-flight:** 2 transactions outstanding, assert `rst_ni` for 1 cycle.
  - `count` is 0 and all outputs return to reset values.
  - A subsequent port 0 request is granted first.
